// File: rtl/bram_arb_pkg.sv
// Shared types and helpers for the two-client BRAM port arbiter.
package bram_arb_pkg;

  localparam logic CLIENT0 = 1'b0;
  localparam logic CLIENT1 = 1'b1;

  typedef enum logic [1:0] {
    ST_ARB   = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } state_t;

  // One in-flight read: valid bit plus the client that issued it.
  typedef struct packed {
    logic vld;
    logic owner;
  } rd_tag_t;

  // Round-robin pick between two requesters; returns the grant one-hot.
  function automatic logic [1:0] rr_pick(input logic [1:0] valid, input logic prio);
    if (valid == 2'b11) return (prio == CLIENT1) ? 2'b10 : 2'b01;
    return valid;
  endfunction

endpackage

// File: rtl/bram_port_arbiter_if.sv
// Client-side request/response bundle of the BRAM port arbiter.
interface bram_port_arbiter_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 4
);
  logic              valid;
  logic              ready;
  logic              we;
  logic              lock;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (output valid, we, lock, addr, wdata, input ready, rvalid, rdata);
  modport slave  (input valid, we, lock, addr, wdata, output ready, rvalid, rdata);
endinterface

// File: rtl/bram_arb_rdpipe.sv
// Tracks in-flight reads for READ_LAT cycles and routes BRAM read data to the issuing client.
module bram_arb_rdpipe
  import bram_arb_pkg::*;
#(
  parameter int unsigned DATA_W   = 4,
  parameter int unsigned READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_rd,
  input  logic              issue_owner,
  input  logic [DATA_W-1:0] bram_rdata,
  output logic              busy_c,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1
);

  rd_tag_t [READ_LAT-1:0] pipe_q;
  rd_tag_t                tag_in;
  rd_tag_t                tail;

  always_comb begin
    tag_in.vld   = issue_rd;
    tag_in.owner = issue_owner;
  end

  generate
    if (READ_LAT == 1) begin : g_lat1
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pipe_q <= '0;
        else        pipe_q[0] <= tag_in;
      end
    end else begin : g_latn
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pipe_q <= '0;
        else        pipe_q <= {pipe_q[READ_LAT-2:0], tag_in};
      end
    end
  endgenerate

  always_comb begin
    busy_c = 1'b0;
    for (int i = 0; i < int'(READ_LAT); i++) busy_c = busy_c | pipe_q[i].vld;
  end

  assign tail = pipe_q[READ_LAT-1];

  // Extra output stage: data is sampled the cycle the BRAM presents it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      rvalid0 <= tail.vld && (tail.owner == CLIENT0);
      rvalid1 <= tail.vld && (tail.owner == CLIENT1);
      if (tail.vld && (tail.owner == CLIENT0)) rdata0 <= bram_rdata;
      if (tail.vld && (tail.owner == CLIENT1)) rdata1 <= bram_rdata;
    end
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one BRAM port between two valid/ready clients with round-robin and bounded lock.
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned DATA_W   = 4,
  parameter int unsigned READ_LAT = 1,
  parameter int unsigned LOCK_MAX = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bram_port_arbiter_if.slave    c0,
  bram_port_arbiter_if.slave    c1,
  output logic [ADDR_W-1:0]     bram_addr,
  output logic [DATA_W-1:0]     bram_wdata,
  output logic                  bram_we,
  output logic                  bram_clken,
  input  logic [DATA_W-1:0]     bram_rdata
);

  localparam int unsigned      CNT_W    = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

  state_t           state_q, state_d;
  logic             prio_q, prio_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       valid, lock, gnt;
  logic             owner;
  logic             gnt_we;
  logic             rd_busy_c;

  assign valid = {c1.valid, c0.valid};
  assign lock  = {c1.lock, c0.lock};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ARB;
      prio_q  <= CLIENT0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    cnt_d   = cnt_q;
    gnt     = 2'b00;
    owner   = CLIENT0;
    unique case (state_q)
      ST_ARB: begin
        gnt = rr_pick(valid, prio_q);
        if (valid == 2'b11) prio_d = gnt[0] ? CLIENT1 : CLIENT0;
        if ((LOCK_MAX > 1) && ((gnt & lock) != 2'b00)) begin
          state_d = gnt[1] ? ST_LOCK1 : ST_LOCK0;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_LOCK0, ST_LOCK1: begin
        owner      = (state_q == ST_LOCK1) ? CLIENT1 : CLIENT0;
        gnt[owner] = valid[owner];
        // Idle owner, dropped lock or exhausted budget all hand the port back.
        if (!valid[owner] || !lock[owner] || (cnt_q >= CNT_LAST)) begin
          state_d = ST_ARB;
          prio_d  = ~owner;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_ARB;
    endcase
    if (!rst_n) gnt = 2'b00;
  end

  always_comb begin
    bram_addr  = '0;
    bram_wdata = '0;
    gnt_we     = 1'b0;
    if (gnt[0]) begin
      bram_addr  = c0.addr;
      bram_wdata = c0.wdata;
      gnt_we     = c0.we;
    end else if (gnt[1]) begin
      bram_addr  = c1.addr;
      bram_wdata = c1.wdata;
      gnt_we     = c1.we;
    end
  end

  assign c0.ready   = gnt[0];
  assign c1.ready   = gnt[1];
  assign bram_we    = gnt_we;
  assign bram_clken = (gnt != 2'b00) || rd_busy_c;

  bram_arb_rdpipe #(
    .DATA_W   (DATA_W),
    .READ_LAT (READ_LAT)
  ) u_rdpipe (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_rd    ((gnt != 2'b00) && !gnt_we),
    .issue_owner (gnt[1]),
    .bram_rdata  (bram_rdata),
    .busy_c      (rd_busy_c),
    .rvalid0     (c0.rvalid),
    .rdata0      (c0.rdata),
    .rvalid1     (c1.rvalid),
    .rdata1      (c1.rdata)
  );

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: READ_LAT=1 and READ_LAT=2 instances driven by identical stimulus.
module tb_bram_port_arbiter;

  localparam int unsigned ADDR_W   = 10;
  localparam int unsigned DATA_W   = 4;
  localparam int unsigned LOCK_MAX = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              v [2];
  logic              we[2];
  logic              lk[2];
  logic [ADDR_W-1:0] ad[2];
  logic [DATA_W-1:0] wd[2];

  bram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) c0_a ();
  bram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) c1_a ();
  bram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) c0_b ();
  bram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) c1_b ();

  assign c0_a.valid = v[0];  assign c0_a.we = we[0]; assign c0_a.lock = lk[0];
  assign c0_a.addr  = ad[0]; assign c0_a.wdata = wd[0];
  assign c1_a.valid = v[1];  assign c1_a.we = we[1]; assign c1_a.lock = lk[1];
  assign c1_a.addr  = ad[1]; assign c1_a.wdata = wd[1];
  assign c0_b.valid = v[0];  assign c0_b.we = we[0]; assign c0_b.lock = lk[0];
  assign c0_b.addr  = ad[0]; assign c0_b.wdata = wd[0];
  assign c1_b.valid = v[1];  assign c1_b.we = we[1]; assign c1_b.lock = lk[1];
  assign c1_b.addr  = ad[1]; assign c1_b.wdata = wd[1];

  logic [ADDR_W-1:0] ba_addr, bb_addr;
  logic [DATA_W-1:0] ba_wdata, bb_wdata, ba_rdata, bb_rdata;
  logic              ba_we, bb_we, ba_clken, bb_clken;

  bram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LAT(1), .LOCK_MAX(LOCK_MAX)) dut_a (
    .clk(clk), .rst_n(rst_n), .c0(c0_a), .c1(c1_a),
    .bram_addr(ba_addr), .bram_wdata(ba_wdata), .bram_we(ba_we),
    .bram_clken(ba_clken), .bram_rdata(ba_rdata));

  bram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LAT(2), .LOCK_MAX(LOCK_MAX)) dut_b (
    .clk(clk), .rst_n(rst_n), .c0(c0_b), .c1(c1_b),
    .bram_addr(bb_addr), .bram_wdata(bb_wdata), .bram_we(bb_we),
    .bram_clken(bb_clken), .bram_rdata(bb_rdata));

  function automatic logic [DATA_W-1:0] init_val(input int i);
    return DATA_W'((i * 5 + 3) ^ (i >> 4));
  endfunction

  // Behavioural BRAMs: write-then-read, optional output register on instance b.
  logic [DATA_W-1:0] mem_a [1024];
  logic [DATA_W-1:0] mem_b [1024];
  logic [DATA_W-1:0] rd_a, rd1_b, rd2_b;
  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem_a[i] = init_val(i);
      mem_b[i] = init_val(i);
    end
  end
  always @(posedge clk) begin
    if (ba_clken) begin
      if (ba_we) mem_a[ba_addr] <= ba_wdata;
      else       rd_a <= mem_a[ba_addr];
    end
    if (bb_clken) begin
      if (bb_we) mem_b[bb_addr] <= bb_wdata;
      else       rd1_b <= mem_b[bb_addr];
    end
    rd2_b <= rd1_b;
  end
  assign ba_rdata = rd_a;
  assign bb_rdata = rd2_b;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Reference model: arbitration rules plus a memory image and a response schedule.
  int                m_prio = 0, m_held = -1, m_streak = 0, m_g = -1, m_last_g = -1;
  logic [DATA_W-1:0] ref_mem [1024];
  bit                sv [2][16];
  bit                sc [2][16];
  logic [DATA_W-1:0] sd [2][16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic clear_sched();
    for (int l = 0; l < 2; l++)
      for (int s = 0; s < 16; s++) sv[l][s] = 1'b0;
  endtask

  function automatic int model_grant();
    if (!rst_n) return -1;
    if (m_held >= 0) return v[m_held] ? m_held : -1;
    if (v[0] && v[1]) return m_prio;
    if (v[0]) return 0;
    if (v[1]) return 1;
    return -1;
  endfunction

  task automatic sample();
    int g, slot;
    bit infl;
    logic r0, r1, rv0, rv1, bwe, ck;
    logic [ADDR_W-1:0] baddr;
    logic [DATA_W-1:0] bw, q0, q1;
    @(negedge clk);
    if (!rst_n) clear_sched();
    g = model_grant();
    slot = cyc % 16;
    for (int l = 0; l < 2; l++) begin
      if (l == 0) begin
        r0 = c0_a.ready; r1 = c1_a.ready; rv0 = c0_a.rvalid; rv1 = c1_a.rvalid;
        q0 = c0_a.rdata; q1 = c1_a.rdata; bwe = ba_we; ck = ba_clken; baddr = ba_addr; bw = ba_wdata;
      end else begin
        r0 = c0_b.ready; r1 = c1_b.ready; rv0 = c0_b.rvalid; rv1 = c1_b.rvalid;
        q0 = c0_b.rdata; q1 = c1_b.rdata; bwe = bb_we; ck = bb_clken; baddr = bb_addr; bw = bb_wdata;
      end
      chk($sformatf("ready0_lat%0d", l + 1), 32'(r0), 32'(g == 0));
      chk($sformatf("ready1_lat%0d", l + 1), 32'(r1), 32'(g == 1));
      chk($sformatf("bram_we_lat%0d", l + 1), 32'(bwe), 32'(g >= 0 && we[g]));
      if (g >= 0) begin
        chk($sformatf("bram_addr_lat%0d", l + 1), 32'(baddr), 32'(ad[g]));
        if (we[g]) chk($sformatf("bram_wdata_lat%0d", l + 1), 32'(bw), 32'(wd[g]));
      end
      infl = 1'b0;
      for (int k = 1; k <= l + 1; k++) if (sv[l][(cyc + k) % 16]) infl = 1'b1;
      chk($sformatf("clken_lat%0d", l + 1), 32'(ck), 32'(g >= 0 || infl));
      chk($sformatf("rvalid0_lat%0d", l + 1), 32'(rv0), 32'(sv[l][slot] && !sc[l][slot]));
      chk($sformatf("rvalid1_lat%0d", l + 1), 32'(rv1), 32'(sv[l][slot] && sc[l][slot]));
      if (sv[l][slot]) begin
        if (sc[l][slot]) chk($sformatf("rdata1_lat%0d", l + 1), 32'(q1), 32'(sd[l][slot]));
        else             chk($sformatf("rdata0_lat%0d", l + 1), 32'(q0), 32'(sd[l][slot]));
      end
      sv[l][slot] = 1'b0;
    end
    m_g = g;
  endtask

  task automatic advance();
    int g, due;
    g = m_g;
    if (!rst_n) begin
      m_prio = 0; m_held = -1; m_streak = 0;
    end else begin
      if (m_held >= 0) begin
        if (g < 0) begin
          m_prio = 1 - m_held; m_held = -1;
        end else begin
          m_streak++;
          if (!lk[g] || m_streak >= int'(LOCK_MAX)) begin m_held = -1; m_prio = 1 - g; end
        end
      end else begin
        if (v[0] && v[1]) m_prio = 1 - g;
        if (g >= 0 && lk[g] && LOCK_MAX > 1) begin m_held = g; m_streak = 1; end
      end
      if (g >= 0) begin
        if (we[g]) ref_mem[ad[g]] = wd[g];
        else for (int l = 0; l < 2; l++) begin
          due = cyc + l + 2;
          sv[l][due % 16] = 1'b1;
          sc[l][due % 16] = (g == 1);
          sd[l][due % 16] = ref_mem[ad[g]];
        end
      end
    end
    m_last_g = m_g;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    sample();
    advance();
  endtask

  task automatic drive(input logic v0, input logic v1, input logic w0, input logic w1,
                       input logic l0, input logic l1, input logic [ADDR_W-1:0] a0,
                       input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d0,
                       input logic [DATA_W-1:0] d1);
    v[0] = v0; v[1] = v1; we[0] = w0; we[1] = w1; lk[0] = l0; lk[1] = l1;
    ad[0] = a0; ad[1] = a1; wd[0] = d0; wd[1] = d1;
  endtask

  typedef struct {
    logic v0, v1, we0, we1, l0, l1;
    logic [ADDR_W-1:0] a0, a1;
    logic [DATA_W-1:0] d0, d1;
    logic er0, er1, ewe;
  } vec_t;

  function automatic vec_t row(input logic v0, input logic v1, input logic w0, input logic w1,
                               input logic l0, input logic l1, input int a0, input int a1,
                               input int d1, input logic er0, input logic er1, input logic ewe);
    vec_t r;
    r.v0 = v0; r.v1 = v1; r.we0 = w0; r.we1 = w1; r.l0 = l0; r.l1 = l1;
    r.a0 = ADDR_W'(a0); r.a1 = ADDR_W'(a1); r.d0 = '0; r.d1 = DATA_W'(d1);
    r.er0 = er0; r.er1 = er1; r.ewe = ewe;
    return r;
  endfunction

  vec_t tbl [16];

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, cnt;
    bit got1;
    tbl[0]  = row(1, 1, 0, 0, 0, 0, 'h010, 'h020, 0, 1, 0, 0);
    tbl[1]  = row(1, 1, 0, 0, 0, 0, 'h011, 'h020, 0, 0, 1, 0);
    tbl[2]  = row(1, 1, 0, 0, 0, 0, 'h011, 'h021, 0, 1, 0, 0);
    tbl[3]  = row(0, 1, 0, 0, 0, 0, 'h000, 'h021, 0, 0, 1, 0);
    tbl[4]  = row(1, 0, 0, 0, 0, 0, 'h012, 'h000, 0, 1, 0, 0);
    tbl[5]  = row(0, 1, 0, 0, 0, 0, 'h000, 'h022, 0, 0, 1, 0);
    tbl[6]  = row(0, 1, 0, 1, 0, 0, 'h000, 'h155, 'hA, 0, 1, 1);
    tbl[7]  = row(1, 0, 0, 0, 0, 0, 'h155, 'h000, 0, 1, 0, 0);
    tbl[8]  = row(0, 0, 0, 0, 0, 0, 'h000, 'h000, 0, 0, 0, 0);
    tbl[9]  = row(1, 0, 0, 0, 1, 0, 'h014, 'h000, 0, 1, 0, 0);
    tbl[10] = row(0, 1, 0, 0, 0, 0, 'h000, 'h023, 0, 0, 0, 0);
    tbl[11] = row(0, 1, 0, 0, 0, 0, 'h000, 'h023, 0, 0, 1, 0);
    tbl[12] = row(1, 1, 0, 0, 0, 0, 'h015, 'h024, 0, 0, 1, 0);
    tbl[13] = row(1, 1, 0, 0, 0, 0, 'h015, 'h025, 0, 1, 0, 0);
    tbl[14] = row(0, 1, 0, 0, 0, 0, 'h000, 'h025, 0, 0, 1, 0);
    tbl[15] = row(0, 0, 0, 0, 0, 0, 'h000, 'h000, 0, 0, 0, 0);
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);
    clear_sched();

    // Reset held with both clients requesting.
    drive(1, 1, 0, 0, 0, 0, 10'h010, 10'h020, '0, '0);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("reset_rdata0", 32'(c0_a.rdata), 32'h0);
      chk("reset_rvalid1_lat2", 32'(c1_b.rvalid), 32'h0);
      advance();
    end
    rst_n = 1'b1;

    // Directed arbitration table.
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].v0, tbl[i].v1, tbl[i].we0, tbl[i].we1, tbl[i].l0, tbl[i].l1,
            tbl[i].a0, tbl[i].a1, tbl[i].d0, tbl[i].d1);
      sample();
      chk($sformatf("tbl%0d_ready0", i), 32'(c0_a.ready), 32'(tbl[i].er0));
      chk($sformatf("tbl%0d_ready1", i), 32'(c1_a.ready), 32'(tbl[i].er1));
      chk($sformatf("tbl%0d_we", i), 32'(ba_we), 32'(tbl[i].ewe));
      advance();
    end
    for (int i = 0; i < 3; i++) step();

    // Single client, back-to-back reads of addresses 0,1,2.
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 0, 0, ADDR_W'(i), '0, '0, '0);
      step();
    end
    drive(0, 0, 0, 0, 0, 0, '0, '0, '0, '0);
    for (int i = 0; i < 4; i++) step();

    // Bounded lock burst from client 0 while client 1 waits.
    n0 = 0; got1 = 1'b0;
    for (int i = 0; i < 20 && !got1; i++) begin
      drive(1, (i >= 1), 0, 0, 1, 0, ADDR_W'(64 + i), 10'h033, '0, '0);
      sample();
      if (c1_a.ready) got1 = 1'b1;
      else if (c0_a.ready) n0++;
      advance();
    end
    chk("lock_c0_grants", 32'(n0), 32'(LOCK_MAX));
    chk("lock_c1_granted", 32'(got1), 32'h1);
    ad[1] = '0; v[1] = 1'b0; lk[0] = 1'b0;
    step();
    drive(0, 0, 0, 0, 0, 0, '0, '0, '0, '0);
    for (int i = 0; i < 4; i++) step();

    // Reset pulse with two reads in flight.
    drive(1, 0, 0, 0, 0, 0, 10'h100, '0, '0, '0); step();
    drive(1, 0, 0, 0, 0, 0, 10'h101, '0, '0, '0); step();
    drive(0, 0, 0, 0, 0, 0, '0, '0, '0, '0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      sample();
      cnt += int'(c0_b.rvalid) + int'(c1_b.rvalid) + int'(c0_a.rvalid) + int'(c1_a.rvalid);
      advance();
    end
    chk("no_rvalid_after_reset", 32'(cnt), 32'h0);
    drive(1, 1, 0, 0, 0, 0, 10'h102, 10'h103, '0, '0);
    sample();
    chk("post_reset_c0_first", 32'(c0_b.ready), 32'h1);
    advance();
    v[0] = 1'b0; step();
    drive(0, 0, 0, 0, 0, 0, '0, '0, '0, '0);
    for (int i = 0; i < 4; i++) step();

    // Random traffic against the reference model.
    for (int n = 0; n < 600; n++) begin
      for (int c = 0; c < 2; c++) begin
        if (!(v[c] && m_last_g != c)) begin
          v[c]  = ($urandom % 4) != 0;
          we[c] = ($urandom % 3) == 0;
          lk[c] = ($urandom % 4) == 0;
          ad[c] = ADDR_W'($urandom % 16);
          wd[c] = DATA_W'($urandom);
        end
      end
      step();
    end
    drive(0, 0, 0, 0, 0, 0, '0, '0, '0, '0);
    for (int i = 0; i < 6; i++) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
